// File: rtl/vmu_sched.sv
// Video-memory-unit scheduler: round-robin matrix-port arbiter between host writes and
// matrix-unit reads, an object valid table, and a clip scan engine over the valid slots.
module vmu_sched #(
    parameter int NUM_OBJ = 32
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       wr_req,
    input  logic [4:0] wr_addr,
    output logic       wr_gnt,
    input  logic       rd_req,
    input  logic       rd_ldback,
    input  logic [4:0] rd_addr,
    output logic       rd_gnt,
    output logic       rd_data_vld,
    input  logic       obj_clear,
    input  logic       clip_start,
    input  logic [5:0] clip_obj_cnt,
    input  logic       clip_stall,
    output logic       clip_busy,
    output logic       clip_vld,
    output logic [4:0] clip_idx,
    output logic       clip_done,
    output logic [4:0] mat_addr,
    output logic       mat_wr_en,
    output logic       mat_rd_en,
    output logic       loadback,
    output logic       clip_rd_en,
    output logic [4:0] clip_addr,
    output logic [1:0] clip_state
);
    typedef enum logic [1:0] {IDLE = 2'd0, SCAN = 2'd1, DONE = 2'd2} clip_st_t;

    clip_st_t           st_q, st_d;
    logic [4:0]         idx_q, idx_d;
    logic [5:0]         cnt_q, cnt_d, cnt_sat;
    logic               hold_q, hold_d;
    logic [NUM_OBJ-1:0] valid_q, valid_d;
    logic               last_rd_q;
    logic               wr_ok, rd_ok, grant_w, grant_r;
    logic               stall_d, issue_d;

    assign clip_state = st_q;

    // Handshake: a request sampled at an edge yields a one-cycle gnt (plus mat_* drive) in the
    // following cycle; a request seen while its own gnt is high is ignored, so holders never double-win.
    assign wr_ok   = wr_req & ~wr_gnt;
    assign rd_ok   = rd_req & ~rd_gnt;
    assign grant_w = wr_ok & (~rd_ok | last_rd_q);
    assign grant_r = rd_ok & ~grant_w;
    assign cnt_sat = (clip_obj_cnt > 6'(NUM_OBJ)) ? 6'(NUM_OBJ) : clip_obj_cnt;

    // Clear first, then the write finishing at this edge, so a simultaneous write survives.
    always_comb begin
        valid_d = obj_clear ? '0 : valid_q;
        if (wr_gnt) valid_d[mat_addr] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            st_q   <= IDLE;
            idx_q  <= '0;
            cnt_q  <= '0;
            hold_q <= 1'b0;
        end else begin
            st_q   <= st_d;
            idx_q  <= idx_d;
            cnt_q  <= cnt_d;
            hold_q <= hold_d;
        end
    end

    always_comb begin
        st_d  = st_q;
        idx_d = idx_q;
        cnt_d = cnt_q;
        case (st_q)
            IDLE: if (clip_start) begin
                cnt_d = cnt_sat;
                idx_d = '0;
                st_d  = (cnt_sat == 6'd0) ? DONE : SCAN;
            end
            SCAN: if (!hold_q) begin
                if ({1'b0, idx_q} == cnt_q - 6'd1) st_d = DONE;
                else idx_d = idx_q + 5'd1;
            end
            DONE:    st_d = IDLE;
            default: st_d = IDLE;
        endcase
    end

    // The slot for the next cycle is decided here; a write landing on it that cycle forces a stall.
    always_comb begin
        stall_d = clip_stall | (grant_w & (wr_addr == idx_d));
        issue_d = (st_d == SCAN) & ~stall_d & valid_d[idx_d];
        hold_d  = (st_d == SCAN) & stall_d;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_gnt      <= 1'b0;
            rd_gnt      <= 1'b0;
            rd_data_vld <= 1'b0;
            mat_wr_en   <= 1'b0;
            mat_rd_en   <= 1'b0;
            loadback    <= 1'b0;
            mat_addr    <= '0;
            last_rd_q   <= 1'b1;
            valid_q     <= '0;
            clip_rd_en  <= 1'b0;
            clip_addr   <= '0;
            clip_vld    <= 1'b0;
            clip_idx    <= '0;
            clip_done   <= 1'b0;
            clip_busy   <= 1'b0;
        end else begin
            wr_gnt      <= grant_w;
            rd_gnt      <= grant_r;
            rd_data_vld <= rd_gnt;
            mat_wr_en   <= grant_w;
            mat_rd_en   <= grant_r & ~rd_ldback;
            loadback    <= grant_r & rd_ldback;
            mat_addr    <= grant_w ? wr_addr : (grant_r ? rd_addr : 5'd0);
            if (grant_w)      last_rd_q <= 1'b0;
            else if (grant_r) last_rd_q <= 1'b1;
            valid_q     <= valid_d;
            clip_rd_en  <= issue_d;
            clip_addr   <= issue_d ? idx_d : 5'd0;
            clip_vld    <= clip_rd_en;
            clip_idx    <= clip_addr;
            clip_done   <= (st_d == DONE);
            clip_busy   <= (st_d != IDLE);
        end
    end
endmodule

// File: tb/tb_vmu_sched.sv
// Directed bench for vmu_sched: arbitration, loadback, clip scans with stalls, write hazard,
// clears, saturation and reset abort, with a small object memory model behind the ports.
module tb_vmu_sched;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       wr_req = 1'b0, rd_req = 1'b0, rd_ldback = 1'b0;
    logic [4:0] wr_addr = '0, rd_addr = '0;
    logic       obj_clear = 1'b0, clip_start = 1'b0, clip_stall = 1'b0;
    logic [5:0] clip_obj_cnt = '0;
    logic       wr_gnt, rd_gnt, rd_data_vld, clip_busy, clip_vld, clip_done;
    logic [4:0] clip_idx, mat_addr, clip_addr;
    logic       mat_wr_en, mat_rd_en, loadback, clip_rd_en;
    logic [1:0] clip_state;

    logic [15:0] mat_obj_in = '0;
    logic [15:0] mem [32];
    logic [15:0] clip_obj_out;

    int checks = 0;
    int errors = 0;
    int nreads, done_cyc;

    vmu_sched dut (
        .clk(clk), .rst(rst), .wr_req(wr_req), .wr_addr(wr_addr), .wr_gnt(wr_gnt),
        .rd_req(rd_req), .rd_ldback(rd_ldback), .rd_addr(rd_addr), .rd_gnt(rd_gnt),
        .rd_data_vld(rd_data_vld), .obj_clear(obj_clear), .clip_start(clip_start),
        .clip_obj_cnt(clip_obj_cnt), .clip_stall(clip_stall), .clip_busy(clip_busy),
        .clip_vld(clip_vld), .clip_idx(clip_idx), .clip_done(clip_done),
        .mat_addr(mat_addr), .mat_wr_en(mat_wr_en), .mat_rd_en(mat_rd_en),
        .loadback(loadback), .clip_rd_en(clip_rd_en), .clip_addr(clip_addr),
        .clip_state(clip_state)
    );

    always #5 clk = ~clk;

    // Object memory: writes land at the edge ending the grant cycle, clip reads see pre-edge data.
    always @(posedge clk) begin
        if (mat_wr_en) mem[mat_addr] <= mat_obj_in;
        if (clip_rd_en) clip_obj_out <= mem[clip_addr];
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wr_obj(input logic [4:0] a, input logic [15:0] d);
        wr_req = 1'b1; wr_addr = a; mat_obj_in = d;
        tick();
        chk("wr_gnt", wr_gnt, 1);
        chk("wr_mat_wr_en", mat_wr_en, 1);
        chk("wr_mat_addr", mat_addr, a);
        wr_req = 1'b0;
        tick();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL timeout");
        $fatal(1, "timeout");
    end

    initial begin
        // Reset state
        tick(); tick();
        chk("rst_wr_gnt", wr_gnt, 0);
        chk("rst_rd_gnt", rd_gnt, 0);
        chk("rst_busy", clip_busy, 0);
        chk("rst_done", clip_done, 0);
        chk("rst_rd_en", clip_rd_en, 0);
        chk("rst_state", clip_state, 0);
        rst = 1'b0;

        // Loadback read of slot 7
        rd_req = 1'b1; rd_ldback = 1'b1; rd_addr = 5'd7;
        tick();
        chk("lb_rd_gnt", rd_gnt, 1);
        chk("lb_loadback", loadback, 1);
        chk("lb_mat_rd_en", mat_rd_en, 0);
        chk("lb_mat_addr", mat_addr, 7);
        chk("lb_wr_en", mat_wr_en, 0);
        rd_req = 1'b0; rd_ldback = 1'b0;
        tick();
        chk("lb_data_vld", rd_data_vld, 1);
        chk("lb_rd_gnt_drop", rd_gnt, 0);

        // Both requests held from reset: W,R,W,R...
        rst = 1'b1;
        wr_req = 1'b1; rd_req = 1'b1; wr_addr = 5'd3; rd_addr = 5'd9; mat_obj_in = 16'h1111;
        tick();
        chk("rr_inrst_wr", wr_gnt, 0);
        chk("rr_inrst_rd", rd_gnt, 0);
        rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick();
            chk("rr_wr_gnt", wr_gnt, (i % 2 == 0) ? 1 : 0);
            chk("rr_rd_gnt", rd_gnt, (i % 2 == 1) ? 1 : 0);
            chk("rr_mat_addr", mat_addr, (i % 2 == 0) ? 3 : 9);
            chk("rr_mat_rd_en", mat_rd_en, (i % 2 == 1) ? 1 : 0);
        end
        wr_req = 1'b0; rd_req = 1'b0;
        tick();
        do_reset();

        // Write slots 0..3, scan 4
        for (int a = 0; a < 4; a++) wr_obj(5'(a), 16'hA000 + 16'(a));
        clip_start = 1'b1; clip_obj_cnt = 6'd4;
        tick();
        clip_start = 1'b0;
        for (int k = 0; k < 4; k++) begin
            chk("s4_rd_en", clip_rd_en, 1);
            chk("s4_addr", clip_addr, k);
            chk("s4_busy", clip_busy, 1);
            chk("s4_done_low", clip_done, 0);
            chk("s4_vld", clip_vld, (k > 0) ? 1 : 0);
            if (k > 0) begin
                chk("s4_idx", clip_idx, k - 1);
                chk("s4_obj", clip_obj_out, 16'hA000 + 16'(k - 1));
            end
            tick();
        end
        chk("s4_done", clip_done, 1);
        chk("s4_last_vld", clip_vld, 1);
        chk("s4_last_idx", clip_idx, 3);
        chk("s4_last_obj", clip_obj_out, 16'hA003);
        chk("s4_rd_en_end", clip_rd_en, 0);
        tick();
        chk("s4_done_pulse", clip_done, 0);
        chk("s4_busy_end", clip_busy, 0);

        // Stall for 3 cycles, then write hazard on slot 3
        wr_obj(5'd4, 16'hA004);
        wr_obj(5'd5, 16'hA005);
        clip_start = 1'b1; clip_obj_cnt = 6'd6;
        tick();
        clip_start = 1'b0;
        chk("st_rd0", clip_addr, 0);
        tick();
        chk("st_rd1", clip_addr, 1);
        clip_stall = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("st_frozen_rd_en", clip_rd_en, 0);
            chk("st_busy", clip_busy, 1);
        end
        clip_stall = 1'b0;
        tick();
        chk("st_resume_en", clip_rd_en, 1);
        chk("st_resume_addr", clip_addr, 2);
        wr_req = 1'b1; wr_addr = 5'd3; mat_obj_in = 16'hBEEF;
        tick();
        chk("hz_wr_gnt", wr_gnt, 1);
        chk("hz_stall", clip_rd_en, 0);
        wr_req = 1'b0;
        tick();
        chk("hz_rd_en", clip_rd_en, 1);
        chk("hz_addr", clip_addr, 3);
        tick();
        chk("hz_vld", clip_vld, 1);
        chk("hz_idx", clip_idx, 3);
        chk("hz_new_obj", clip_obj_out, 16'hBEEF);
        chk("hz_addr4", clip_addr, 4);
        tick();
        chk("hz_addr5", clip_addr, 5);
        tick();
        chk("hz_done", clip_done, 1);
        tick();
        chk("hz_idle", clip_busy, 0);

        // Count zero
        clip_start = 1'b1; clip_obj_cnt = 6'd0;
        tick();
        clip_start = 1'b0;
        chk("c0_done", clip_done, 1);
        chk("c0_busy", clip_busy, 1);
        chk("c0_no_rd", clip_rd_en, 0);
        tick();
        chk("c0_done_pulse", clip_done, 0);
        chk("c0_idle", clip_busy, 0);

        // Clear mid-scan, with a write to slot 4 completing on the clearing edge
        clip_start = 1'b1; clip_obj_cnt = 6'd6;
        tick();
        clip_start = 1'b0;
        chk("cl_rd0", clip_rd_en, 1);
        wr_req = 1'b1; wr_addr = 5'd4; mat_obj_in = 16'hC004;
        tick();
        chk("cl_wr_gnt", wr_gnt, 1);
        chk("cl_rd1", clip_addr, 1);
        wr_req = 1'b0; obj_clear = 1'b1;
        for (int k = 2; k < 6; k++) begin
            tick();
            obj_clear = 1'b0;
            chk("cl_rd_en", clip_rd_en, (k == 4) ? 1 : 0);
            if (k == 4) chk("cl_addr", clip_addr, 4);
        end
        tick();
        chk("cl_done", clip_done, 1);
        tick();

        // Only slots 2 and 5 valid, count 6
        do_reset();
        wr_obj(5'd2, 16'hD002);
        wr_obj(5'd5, 16'hD005);
        clip_start = 1'b1; clip_obj_cnt = 6'd6;
        nreads = 0;
        for (int k = 1; k <= 7; k++) begin
            tick();
            clip_start = 1'b0;
            if (clip_rd_en) nreads++;
            if (k <= 6) begin
                chk("sp_rd_en", clip_rd_en, (k == 3 || k == 6) ? 1 : 0);
                if (k == 3 || k == 6) chk("sp_addr", clip_addr, k - 1);
            end
            chk("sp_done", clip_done, (k == 7) ? 1 : 0);
        end
        chk("sp_nreads", nreads, 2);
        tick();

        // Count above 32 saturates to 32 slots
        clip_start = 1'b1; clip_obj_cnt = 6'd40;
        nreads = 0; done_cyc = 0;
        for (int k = 1; k <= 40; k++) begin
            tick();
            clip_start = 1'b0;
            if (clip_rd_en) nreads++;
            if (clip_done) begin
                done_cyc = k;
                break;
            end
        end
        chk("sat_done_cyc", done_cyc, 33);
        chk("sat_nreads", nreads, 2);
        tick();

        // Reset mid-scan aborts without clip_done
        clip_start = 1'b1; clip_obj_cnt = 6'd10;
        tick();
        clip_start = 1'b0;
        tick(); tick();
        chk("ab_busy_before", clip_busy, 1);
        rst = 1'b1;
        tick();
        chk("ab_busy", clip_busy, 0);
        chk("ab_done", clip_done, 0);
        chk("ab_state", clip_state, 0);
        rst = 1'b0;
        tick();
        chk("ab_done_after", clip_done, 0);
        chk("ab_busy_after", clip_busy, 0);
        tick();
        chk("ab_done_after2", clip_done, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
